// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory port bundle for the load/store unit.
// The slave side is the LSU; the master side is the core plus the memory.
interface load_store_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory accesses,
// load extension and read-modify-write for byte/halfword stores.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                   state_r;
  logic                     we_r;
  logic [2:0]               funct3_r;
  logic [1:0]               lane_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]    mem_wdata_r;
  logic                     mem_we_r;
  logic                     rsp_valid_r;
  logic [DATA_WIDTH-1:0]    rsp_rdata_r;
  logic                     rsp_err_r;

  // Illegal width for the direction, or address not aligned to the access size.
  function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    logic misaligned;
    if (we) begin
      bad_f3 = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    end else begin
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned;
  endfunction

  // Select the addressed byte/half of a memory word and sign/zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [2:0] f3,
                                                         input logic [1:0] a);
    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] result;
    shifted = word >> {a, 3'b000};
    b       = shifted[7:0];
    h       = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  result = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b100:  result = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b001:  result = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b101:  result = {{(DATA_WIDTH-16){1'b0}}, h};
      3'b010:  result = word;
      default: result = {DATA_WIDTH{1'b0}};
    endcase
    return result;
  endfunction

  // Overlay right-aligned store data onto the addressed lane(s) of the old word.
  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [DATA_WIDTH-1:0] d,
                                                         input logic [2:0] f3,
                                                         input logic [1:0] a);
    logic [DATA_WIDTH-1:0] m;
    m = word;
    case (f3[1:0])
      2'b00:   m[{a, 3'b000} +: 8] = d[7:0];
      2'b01:   m[{a[1], 4'b0000} +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  // Request sequencing FSM; every bus output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      lane_r      <= 2'b00;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      mem_addr_r  <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
      mem_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      mem_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            lane_r   <= bus.req_addr[1:0];
            wdata_r  <= bus.req_wdata;
            if (req_error(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
              mem_addr_r  <= {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_wdata_r <= bus.req_wdata;
              mem_we_r    <= 1'b1;
              state_r     <= ST_WR;
            end else begin
              mem_addr_r <= {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              state_r    <= ST_RD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          state_r <= ST_DATA;
        end
        ST_DATA: begin
          if (we_r) begin
            mem_wdata_r <= store_merge(bus.mem_rdata, wdata_r, funct3_r, lane_r);
            mem_we_r    <= 1'b1;
            state_r     <= ST_WR;
          end else begin
            rsp_rdata_r <= load_extend(bus.mem_rdata, funct3_r, lane_r);
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_WR: begin
          rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Write enable is masked by reset so an interrupted store never lands.
  assign bus.mem_we    = mem_we_r && !rst;
  assign bus.req_ready = (state_r == ST_IDLE) && !rst;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner
// cases, and random traffic checked against a byte-addressed reference model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Word-organised data memory driven by the DUT; one-cycle read latency.
  logic [31:0] mem_w [64] = '{default: 32'h0};
  // Reference memory kept as bytes, updated only by the model.
  logic [7:0]  ref_mem [256] = '{default: 8'h0};

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem_w[bus.mem_addr[7:2]] <= bus.mem_wdata;
      we_count <= we_count + 1;
    end
    bus.mem_rdata <= mem_w[bus.mem_addr[7:2]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    int w;
    w = int'(a) & 8'hFC;
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  // Reference model: size from funct3, legality table, little-endian bytes, arithmetic extension.
  task automatic model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat);
    int     size;
    bit     legal;
    longint v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err   = !legal || ((int'(a) % size) != 0);
    rd    = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 4;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      rd  = v[31:0];
      lat = 3;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int wes);
    int n;
    int we0;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("ready_wait", {31'h0, bus.req_ready}, 32'h1);
    we0            = we_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = {24'h0, a};
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 10);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    check("ready_during_rsp", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    check("rsp_pulse", {31'h0, bus.rsp_valid}, 32'h0);
    check("ready_after_rsp", {31'h0, bus.req_ready}, 32'h1);
    wes = we_count - we0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, m_rd;
    logic        err, m_err;
    int          lat, m_lat, wes, we0;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  a;
    logic [31:0] wd;

    vecs.push_back('{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 3'b010, 8'h10, 32'h11223344, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 3'b000, 8'h11, 32'h555555AA, 32'h0,        1'b0, 4});
    vecs.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'h1122AA44, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b000, 8'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b100, 8'h11, 32'h0,        32'h000000AA, 1'b0, 3});
    vecs.push_back('{1'b1, 3'b010, 8'h20, 32'h80017FFF, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 3'b001, 8'h22, 32'h0,        32'hFFFF8001, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b101, 8'h22, 32'h0,        32'h00008001, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b001, 8'h20, 32'h0,        32'h00007FFF, 1'b0, 3});
    vecs.push_back('{1'b0, 3'b010, 8'h13, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 3'b001, 8'h21, 32'h1234ABCD, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 3'b011, 8'h20, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 3'b100, 8'h20, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 3'b010, 8'h20, 32'h0,        32'h80017FFF, 1'b0, 3});
    vecs.push_back('{1'b1, 3'b001, 8'h12, 32'h0000BEEF, 32'h0,        1'b0, 4});
    vecs.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hBEEFAA44, 1'b0, 3});

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'h0, bus.req_ready}, 32'h1);

    // Directed vector table
    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat);
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, wes);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_we_pulses", i), wes, (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
      check($sformatf("vec%0d_word", i), mem_w[vecs[i].addr[7:2]], ref_word(vecs[i].addr));
    end

    // Reset for two cycles in the middle of a load
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midlw_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("midlw_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("midlw_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("midlw_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("midlw_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("midlw_mem_addr", bus.mem_addr, 32'h0);
    check("midlw_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midlw_ready_release", {31'h0, bus.req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midlw_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end

    // Reset while a halfword RMW is in its write cycle
    @(negedge clk);
    we0 = we_count;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst_we_pulses", we_count - we0, 32'h0);
    check("rmw_rst_word", mem_w[4], ref_word(8'h10));
    rst = 1'b0;
    #1 check("rmw_rst_idle", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    check("rmw_rst_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      if (we && $urandom_range(0, 9) < 8) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else a = a;
      end
      wd = $urandom;
      model(we, f3, a, wd, m_rd, m_err, m_lat);
      do_req(we, f3, a, wd, rd, err, lat, wes);
      check($sformatf("rnd%0d_rdata", i), rd, m_rd);
      check($sformatf("rnd%0d_err", i), {31'h0, err}, {31'h0, m_err});
      check($sformatf("rnd%0d_latency", i), lat, m_lat);
      check($sformatf("rnd%0d_we_pulses", i), wes, (we && !m_err) ? 1 : 0);
      check($sformatf("rnd%0d_word", i), mem_w[a[7:2]], ref_word(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
